// File: rtl/stepdir_rx.sv
// STEP/DIR/ENABLE receiver: sync, deglitch, position and period tracking,
// with sticky DIR-setup and STEP-width violation flags.
`timescale 1ns/1ps
module stepdir_rx #(
  parameter int FILT_LEN  = 4,
  parameter int POS_W     = 32,
  parameter int PER_W     = 24,
  parameter int DIR_SETUP = 10,
  parameter int MIN_HIGH  = 5,
  parameter int TIMEOUT   = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step_in,
  input  logic             dir_in,
  input  logic             enable_n_in,
  input  logic             clr_pos,
  input  logic             err_clr,
  output logic [POS_W-1:0] position,
  output logic             step_pulse,
  output logic             step_dir,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             moving,
  output logic             err_setup,
  output logic             err_pulse
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int SW = $clog2(DIR_SETUP + 1);
  localparam int HW = $clog2(MIN_HIGH + 1);

  localparam logic [FW-1:0] F_LAST = FW'(FILT_LEN - 1);
  localparam logic [SW-1:0] S_MAX = SW'(DIR_SETUP);
  localparam logic [HW-1:0] H_MAX = HW'(MIN_HIGH);
  localparam logic [PER_W-1:0] T_OUT = PER_W'(TIMEOUT);
  localparam logic [PER_W-1:0] P_MAX = '1;

  localparam logic [1:0] S_DIS   = 2'd0;
  localparam logic [1:0] S_WAIT1 = 2'd1;
  localparam logic [1:0] S_WAIT2 = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  // bit 0 = step, bit 1 = dir, bit 2 = enable_n
  logic [2:0]    pin;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    filt;
  logic [2:0]    chg;
  logic [FW-1:0] fcnt [3];
  logic [1:0]    vld;

  assign pin = {enable_n_in, dir_in, step_in};

  always_comb begin
    chg = '0;
    for (int i = 0; i < 3; i++) begin
      chg[i] = vld[1] && (sync2[i] != filt[i])
               && (fcnt[i] == F_LAST);
    end
  end

  // vld keeps the cleared synchroniser contents out of the filters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      vld   <= '0;
      filt  <= 3'b100;
      for (int i = 0; i < 3; i++) fcnt[i] <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      vld   <= {vld[0], 1'b1};
      filt  <= filt ^ chg;
      for (int i = 0; i < 3; i++) begin
        if (!vld[1] || sync2[i] == filt[i] || chg[i])
          fcnt[i] <= '0;
        else
          fcnt[i] <= fcnt[i] + FW'(1);
      end
    end
  end

  logic step_f;
  logic dir_f;
  logic en_n_f;

  assign step_f = filt[0];
  assign dir_f  = filt[1];
  assign en_n_f = filt[2];

  logic             step_d;
  logic             armed;
  logic [SW-1:0]    scnt;
  logic [HW-1:0]    hcnt;
  logic [PER_W-1:0] pcnt;
  logic [1:0]       state;
  logic [1:0]       state_nxt;

  logic rise;
  logic fall;
  logic evt;
  logic setup_bad;
  logic width_bad;
  logic tmo;

  assign rise = step_f & ~step_d;
  assign fall = ~step_f & step_d;
  assign evt  = rise & armed & ~en_n_f
                & (state != S_DIS);
  assign setup_bad = evt & (chg[1] | (scnt != S_MAX));
  assign width_bad = fall & (hcnt != H_MAX);
  assign tmo = pcnt >= T_OUT;

  always_comb begin
    state_nxt = state;
    if (en_n_f) begin
      state_nxt = S_DIS;
    end else begin
      unique case (state)
        S_DIS:   state_nxt = S_WAIT1;
        S_WAIT1: if (evt) state_nxt = S_WAIT2;
        S_WAIT2: begin
          if (evt)      state_nxt = S_RUN;
          else if (tmo) state_nxt = S_WAIT1;
        end
        S_RUN:   if (!evt && tmo) state_nxt = S_WAIT1;
        default: state_nxt = S_DIS;
      endcase
    end
  end

  // a level present at reset release must drop before it can count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_d <= 1'b0;
      armed  <= 1'b0;
      scnt   <= S_MAX;
      hcnt   <= '0;
      pcnt   <= '0;
      state  <= S_DIS;
    end else begin
      step_d <= step_f;
      armed  <= armed | (vld[1] & ~sync2[0]);
      state  <= state_nxt;
      if (chg[1])
        scnt <= '0;
      else if (scnt != S_MAX)
        scnt <= scnt + SW'(1);
      if (!step_f)
        hcnt <= '0;
      else if (step_d && hcnt != H_MAX)
        hcnt <= hcnt + HW'(1);
      if (en_n_f)
        pcnt <= '0;
      else if (evt)
        pcnt <= PER_W'(1);
      else if (pcnt != P_MAX)
        pcnt <= pcnt + PER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position   <= '0;
      step_pulse <= 1'b0;
      step_dir   <= 1'b0;
      period     <= '0;
      err_setup  <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      step_pulse <= evt;
      if (evt) step_dir <= dir_f;
      if (clr_pos)
        position <= '0;
      else if (evt)
        position <= dir_f ? position - POS_W'(1)
                          : position + POS_W'(1);
      if (evt && state[1])
        period <= pcnt;
      if (setup_bad)    err_setup <= 1'b1;
      else if (err_clr) err_setup <= 1'b0;
      if (width_bad)    err_pulse <= 1'b1;
      else if (err_clr) err_pulse <= 1'b0;
    end
  end

  assign moving       = state[1];
  assign period_valid = (state == S_RUN);

endmodule

// File: tb/tb_stepdir_rx.sv
// Bench for stepdir_rx: step scoreboard plus directed status checks,
// with a 4-bit-position instance for the wrap case.
`timescale 1ns/1ps
module tb_stepdir_rx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic step_in = 1'b0;
  logic dir_in = 1'b0;
  logic enable_n_in = 1'b1;
  logic clr_pos = 1'b0;
  logic err_clr = 1'b0;

  logic [31:0] position;
  logic        step_pulse;
  logic        step_dir;
  logic [23:0] period;
  logic        period_valid;
  logic        moving;
  logic        err_setup;
  logic        err_pulse;

  logic [3:0]  pos4;
  logic        p4_pulse;
  logic        p4_dir;
  logic [23:0] p4_period;
  logic        p4_pv;
  logic        p4_moving;
  logic        p4_es;
  logic        p4_ep;

  always #10 clk = ~clk;

  stepdir_rx #(
    .FILT_LEN(4), .POS_W(32), .PER_W(24),
    .DIR_SETUP(10), .MIN_HIGH(5), .TIMEOUT(1000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .step_in(step_in), .dir_in(dir_in),
    .enable_n_in(enable_n_in),
    .clr_pos(clr_pos), .err_clr(err_clr),
    .position(position), .step_pulse(step_pulse),
    .step_dir(step_dir), .period(period),
    .period_valid(period_valid), .moving(moving),
    .err_setup(err_setup), .err_pulse(err_pulse)
  );

  stepdir_rx #(
    .FILT_LEN(4), .POS_W(4), .PER_W(24),
    .DIR_SETUP(10), .MIN_HIGH(5), .TIMEOUT(1000)
  ) dut4 (
    .clk(clk), .rst_n(rst_n),
    .step_in(step_in), .dir_in(dir_in),
    .enable_n_in(enable_n_in),
    .clr_pos(clr_pos), .err_clr(err_clr),
    .position(pos4), .step_pulse(p4_pulse),
    .step_dir(p4_dir), .period(p4_period),
    .period_valid(p4_pv), .moving(p4_moving),
    .err_setup(p4_es), .err_pulse(p4_ep)
  );

  typedef struct {
    int pos;
    bit dir;
    int per;
    bit cp;
    bit pv;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int mpos = 0;

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(bit cp, int per, bit pv);
    exp_t e;
    mpos = dir_in ? mpos - 1 : mpos + 1;
    e.pos = mpos;
    e.dir = dir_in;
    e.per = per;
    e.cp = cp;
    e.pv = pv;
    q.push_back(e);
  endtask

  task automatic pulse(int hi, int lo);
    step_in = 1'b1;
    cyc(hi);
    step_in = 1'b0;
    cyc(lo);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_pos"}, int'(position), 0);
    chk({tag, "_pulse"}, int'(step_pulse), 0);
    chk({tag, "_dir"}, int'(step_dir), 0);
    chk({tag, "_period"}, int'(period), 0);
    chk({tag, "_pv"}, int'(period_valid), 0);
    chk({tag, "_moving"}, int'(moving), 0);
    chk({tag, "_es"}, int'(err_setup), 0);
    chk({tag, "_ep"}, int'(err_pulse), 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (rst_n && step_pulse) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_step: got pulse pos %0d want none",
                 $signed(position));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_pos", int'($signed(position)), e.pos);
        chk("sb_dir", int'(step_dir), int'(e.dir));
        chk("sb_pv", int'(period_valid), int'(e.pv));
        if (e.cp) chk("sb_period", int'(period), e.per);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    chk_zero("in_rst");
    rst_n = 1'b1;
    cyc(5);
    chk_zero("rst");

    // forward run
    enable_n_in = 1'b0;
    cyc(20);
    chk("wait1_moving", int'(moving), 0);
    for (int k = 0; k < 20; k++) begin
      push(1'b1, (k == 0) ? 0 : 50, k > 0);
      pulse(10, 40);
    end
    chk("fwd_pos", int'($signed(position)), 20);
    chk("fwd_period", int'(period), 50);
    chk("fwd_pv", int'(period_valid), 1);
    chk("fwd_moving", int'(moving), 1);
    chk("fwd_es", int'(err_setup), 0);
    chk("fwd_ep", int'(err_pulse), 0);
    chk("p4_fwd", int'($signed(pos4)), 4);

    // reverse run, clear coincident with a step
    dir_in = 1'b1;
    clr_pos = 1'b1;
    cyc(1);
    clr_pos = 1'b0;
    mpos = 0;
    cyc(1);
    chk("clr_pos", int'($signed(position)), 0);
    cyc(98);
    for (int k = 0; k < 25; k++) begin
      push(1'b1, (k == 0) ? 150 : 50, 1'b1);
      pulse(10, 40);
    end
    chk("rev_pos", int'($signed(position)), -25);
    push(1'b1, 50, 1'b1);
    mpos = 0;
    q[$].pos = 0;
    step_in = 1'b1;
    cyc(6);
    clr_pos = 1'b1;
    cyc(1);
    clr_pos = 1'b0;
    cyc(3);
    step_in = 1'b0;
    cyc(40);
    chk("clr_step_pos", int'($signed(position)), 0);
    chk("rev_es", int'(err_setup), 0);

    // glitches and a short pulse
    repeat (3) pulse(3, 20);
    chk("glitch_pos", int'($signed(position)), 0);
    chk("glitch_ep", int'(err_pulse), 0);
    push(1'b0, 0, 1'b1);
    pulse(5, 40);
    chk("short_ep", int'(err_pulse), 1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
    chk("ep_cleared", int'(err_pulse), 0);

    // late dir change
    dir_in = 1'b0;
    cyc(4);
    push(1'b0, 0, 1'b1);
    pulse(10, 40);
    chk("setup_es", int'(err_setup), 1);
    push(1'b0, 0, 1'b1);
    pulse(10, 40);
    chk("setup_sticky", int'(err_setup), 1);
    err_clr = 1'b1;
    cyc(1);
    err_clr = 1'b0;
    cyc(1);
    chk("es_cleared", int'(err_setup), 0);

    // wrap on the 4-bit instance
    for (int k = 0; k < 6; k++) begin
      push(k > 0, 50, 1'b1);
      pulse(10, 40);
    end
    chk("p4_seven", int'($signed(pos4)), 7);
    push(1'b1, 50, 1'b1);
    pulse(10, 40);
    chk("p4_wrap", int'($signed(pos4)), -8);
    chk("pos_eight", int'($signed(position)), 8);

    // timeout and restart
    cyc(1100);
    chk("tmo_moving", int'(moving), 0);
    chk("tmo_pv", int'(period_valid), 0);
    push(1'b0, 0, 1'b0);
    pulse(10, 40);
    chk("restart_moving", int'(moving), 1);
    chk("restart_pv", int'(period_valid), 0);
    push(1'b1, 50, 1'b1);
    pulse(10, 40);
    chk("restart_pv2", int'(period_valid), 1);

    // disabled
    enable_n_in = 1'b1;
    cyc(20);
    chk("dis_moving", int'(moving), 0);
    chk("dis_pv", int'(period_valid), 0);
    dir_in = 1'b1;
    cyc(4);
    repeat (3) pulse(10, 40);
    chk("dis_pos", int'($signed(position)), 10);
    chk("dis_es", int'(err_setup), 0);

    // reset in the middle of a pulse
    enable_n_in = 1'b0;
    cyc(30);
    push(1'b0, 0, 1'b0);
    step_in = 1'b1;
    cyc(8);
    rst_n = 1'b0;
    mpos = 0;
    cyc(2);
    chk_zero("mid_rst");
    rst_n = 1'b1;
    cyc(30);
    chk("held_pos", int'($signed(position)), 0);
    chk("held_moving", int'(moving), 0);
    step_in = 1'b0;
    cyc(40);
    push(1'b0, 0, 1'b0);
    pulse(10, 40);
    chk("fresh_pos", int'($signed(position)), -1);
    chk("fresh_moving", int'(moving), 1);

    cyc(50);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stepdir_rx.md
Name: stepdir_rx

Overview:
- Receive-side STEP/DIR/ENABLE interface: the consumer of the DRV8825-style step/dir bus our step generators drive.
- Synchronises and deglitches the three inputs, then tracks signed absolute position and measures step period.
- Flags timing violations: DIR setup before STEP, and STEP high width.
- Used as loop-back monitor on the FPGA, and as the front end of a future in-fabric motor driver.

Parameters:
FILT_LEN, 4, consecutive identical synchronised samples needed before a filtered input changes (>=1)
POS_W, 32, position counter width (signed two's complement)
PER_W, 24, period counter width
DIR_SETUP, 10, minimum clk cycles filtered DIR must be stable before a filtered STEP rising edge
MIN_HIGH, 5, minimum clk cycles filtered STEP must stay high
TIMEOUT, 1000000, clk cycles without a counted step before motion is declared stopped (< 2^PER_W - 1)

Ports:
clk  in  1  system clock, 50 MHz
rst_n  in  1  asynchronous active-low reset
step_in  in  1  STEP line, asynchronous to clk
dir_in  in  1  DIR line, asynchronous to clk; 0=CW, 1=CCW
enable_n_in  in  1  ENABLE line, active low, asynchronous to clk
clr_pos  in  1  synchronous position clear
err_clr  in  1  synchronous clear of sticky error flags
position  out  POS_W  signed step position
step_pulse  out  1  one-cycle strobe per counted step
step_dir  out  1  direction of the last counted step
period  out  PER_W  clk cycles between the last two counted steps
period_valid  out  1  period holds a valid measurement
moving  out  1  steps are arriving within TIMEOUT
err_setup  out  1  sticky DIR-setup violation
err_pulse  out  1  sticky STEP high-width violation

Behaviour:
- Reset: all outputs 0; filtered step/dir = 0; filtered enable_n = 1; synchronisers cleared; FSM in DIS.
- Input path, per input: 2-flop synchroniser, then filter. The filtered value takes a new level only after FILT_LEN consecutive cycles of that level. Latency from a pin change to the filtered change is 2+FILT_LEN cycles. Pulses shorter than FILT_LEN cycles are discarded.
- Step event: rising edge of filtered step while filtered enable_n=0.
- On a step event:
  - step_pulse=1 for exactly one cycle, registered one cycle after the filtered edge.
  - position +1 if filtered dir=0, -1 if filtered dir=1. Position wraps two's complement (max+1 -> min).
  - step_dir takes filtered dir.
- clr_pos: position <= 0 next cycle. If a step event occurs in the same cycle, clr wins: position = 0, but step_pulse, step_dir and period still update.
- DIR setup check:
  - A counter resets on every filtered dir change and saturates at DIR_SETUP.
  - A step event with counter < DIR_SETUP sets err_setup. The step is still counted, using the new dir.
- High-width check:
  - A counter counts filtered-step-high cycles, saturating at MIN_HIGH.
  - A filtered falling edge with count < MIN_HIGH sets err_pulse. This applies even when disabled.
- Error flags stay set until err_clr. If err_clr and a new violation occur in the same cycle, the flag stays set.
- Period counter:
  - Cleared to 1 on each step event, increments every cycle, saturates at 2^PER_W-1.
  - On a step event in state RUN or WAIT2, period <= counter value.
- FSM states: DIS, WAIT1, WAIT2, RUN.
  - DIS: filtered enable_n=1. -> WAIT1 when filtered enable_n=0.
  - WAIT1: enabled, no step yet. Step event -> WAIT2.
  - WAIT2: one step seen. Step event -> RUN, period captured.
  - RUN: step events capture period.
  - From WAIT2/RUN: period counter reaching TIMEOUT -> WAIT1.
  - From any state: filtered enable_n=1 -> DIS. Position is kept; the period counter is cleared.
- Outputs by state:
  - moving = 1 in WAIT2 and RUN.
  - period_valid = 1 in RUN only. period holds its last value otherwise.
- In DIS, steps are ignored: no pulse, no position change, no setup error.
- Reset mid-step: everything returns to the reset state immediately. A still-high step_in at release produces no step event until it has been seen low and then high again.

Test Plan (FILT_LEN=4, DIR_SETUP=10, MIN_HIGH=5, TIMEOUT=1000):
- Enable, dir=0, 20 step pulses of 10 high / 40 low cycles -> position=20, 20 single-cycle step_pulse, period=50, period_valid=1 from the 2nd step, no errors.
- Dir=1 held 100 cycles, 25 steps, then clr_pos asserted on the same cycle as the 26th filtered edge -> position=-25 before the clear, 0 after, step_pulse still asserted on that cycle.
- 3-cycle glitches on step_in -> no step_pulse, position unchanged. A 5-cycle pulse -> counted with err_pulse=1. err_clr -> err_pulse=0.
- Dir toggled 4 cycles (filtered) before a step edge -> err_setup=1, step counted with the new direction, flag held until err_clr.
- Steps stop for 1000 cycles -> moving and period_valid drop, FSM in WAIT1. Next two steps -> moving=1, then period_valid=1.
- enable_n_in=1 while stepping -> no counts, moving=0. Assert rst_n low mid-pulse -> all outputs 0; step_in held high through release -> no count until a fresh rising edge. Wrap test with POS_W=4: position 7 plus one CW step -> -8.
